// File: rtl/task_frame_in_pp.sv
// rtl/task_frame_in_pp.sv - multi-bank frame input buffer with whole-frame replay to the core
// Optional feature: TASK_FRAME_IN_OVF_DROP_EN drops oversize frames instead of truncating them.
module task_frame_in_pp #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 243,
  parameter int NUM_BANKS  = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_tdata_valid,
  input  logic [DATA_WIDTH-1:0]            i_tdata,
  input  logic                             i_tdata_last,
  output logic                             o_tready,
  input  logic                             i_output_last,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_enb,
  output logic                             o_first,
  output logic                             o_last,
  output logic [$clog2(MAX_WORDS+1)-1:0]   o_frame_len,
  output logic                             o_overflow
);
  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [LW-1:0] MAX_L     = LW'(MAX_WORDS);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
`ifdef TASK_FRAME_IN_OVF_DROP_EN
  localparam bit DROP_OVERSIZE = 1'b1;
`else
  localparam bit DROP_OVERSIZE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, WAIT_DONE} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][MAX_WORDS];
  logic [NUM_BANKS-1:0]  full, full_nx;
  logic [LW-1:0]         len [NUM_BANKS];
  logic [BW-1:0]         wb, wb_nx, rb;
  logic [LW-1:0]         wcnt, rcnt;
  logic                  ovf;
  logic                  accept, at_cap, ovf_now, commit, commit_ok;
  logic                  start, rd_en, rd_end, free;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  assign accept    = i_tdata_valid && o_tready;
  assign at_cap    = (wcnt == MAX_L);
  // the beat arriving at capacity is itself an overflow beat, even if it is the last one
  assign ovf_now   = ovf || at_cap;
  assign commit    = accept && i_tdata_last;
  assign commit_ok = commit && !(DROP_OVERSIZE && ovf_now);
  assign rd_end    = (rcnt == o_frame_len - 1'b1);

  always_comb begin
    full_nx = full;
    if (commit_ok) full_nx[wb] = 1'b1;
    if (free)      full_nx[rb] = 1'b0;
    wb_nx = commit_ok ? bank_inc(wb) : wb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full       <= '0;
      wb         <= '0;
      wcnt       <= '0;
      ovf        <= 1'b0;
      o_tready   <= 1'b0;
      o_overflow <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) len[i] <= '0;
    end else begin
      full       <= full_nx;
      wb         <= wb_nx;
      o_tready   <= !full_nx[wb_nx];
      o_overflow <= commit && ovf_now;
      if (commit_ok) len[wb] <= at_cap ? MAX_L : wcnt + 1'b1;
      if (commit) begin
        wcnt <= '0;
        ovf  <= 1'b0;
      end else if (accept) begin
        if (at_cap) ovf  <= 1'b1;
        else        wcnt <= wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && !at_cap) mem[wb][wcnt[AW-1:0]] <= i_tdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (full[rb])      state_nx = READ;
      READ:      if (rd_end)        state_nx = WAIT_DONE;
      WAIT_DONE: if (i_output_last) state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_comb begin
    start = (state == IDLE) && full[rb];
    rd_en = (state == READ);
    free  = (state == WAIT_DONE) && i_output_last;
  end

  // replay datapath: flags are address-phase values delayed to line up with the read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rb          <= '0;
      rcnt        <= '0;
      o_frame_len <= '0;
      o_enb       <= 1'b0;
      o_first     <= 1'b0;
      o_last      <= 1'b0;
      o_data      <= '0;
    end else begin
      if (start) begin
        rcnt        <= '0;
        o_frame_len <= len[rb];
      end else if (rd_en) begin
        rcnt <= rcnt + 1'b1;
      end
      if (free) rb <= bank_inc(rb);
      o_enb   <= rd_en;
      o_first <= rd_en && (rcnt == '0);
      o_last  <= rd_en && rd_end;
      if (rd_en) o_data <= mem[rb][rcnt[AW-1:0]];
    end
  end
endmodule

// File: tb/tb_task_frame_in_pp.sv
// tb/tb_task_frame_in_pp.sv - directed bench with a frame-queue scoreboard for task_frame_in_pp
module tb_task_frame_in_pp;
  localparam int DW   = 8;
  localparam int MAXW = 243;
  localparam int NB   = 2;
  localparam int LW   = $clog2(MAXW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tvalid = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tlast = 1'b0;
  logic          output_last = 1'b0;
  logic          o_tready, o_enb, o_first, o_last, o_overflow;
  logic [DW-1:0] o_data;
  logic [LW-1:0] o_frame_len;

  task_frame_in_pp #(.DATA_WIDTH(DW), .MAX_WORDS(MAXW), .NUM_BANKS(NB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata_valid(tvalid), .i_tdata(tdata),
    .i_tdata_last(tlast), .o_tready(o_tready), .i_output_last(output_last),
    .o_data(o_data), .o_enb(o_enb), .o_first(o_first), .o_last(o_last),
    .o_frame_len(o_frame_len), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_data[$];
  bit            exp_first[$], exp_last[$];
  int            exp_len[$];
  int            exp_ovf = 0, ovf_cnt = 0;
  int            frames_done = 0, cur_words = 0, last_words = 0;
  int            last_cyc = 0, first_lat = 0;
  logic [DW-1:0] first_data = '0, last_data = '0, held = '0;
  bit            in_frame = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: waited %0d cycles, required an answer sooner", name, waited);
    summary();
  endtask

  // scoreboard: every enabled word must be the next word of the next committed frame
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else begin
      if (o_overflow) begin
        ovf_cnt++;
        chk("ovf_pulse_cycle", cyc, last_cyc + 1);
      end
      if (o_enb) begin
        if (exp_data.size() == 0) begin
          chk("enb_without_frame", o_enb, 1'b0);
        end else begin
          logic [DW-1:0] ed;
          bit ef, el;
          int en;
          ed = exp_data.pop_front(); ef = exp_first.pop_front();
          el = exp_last.pop_front(); en = exp_len.pop_front();
          chk("data", o_data, ed);
          chk("first", o_first, ef);
          chk("last", o_last, el);
          chk("frame_len", o_frame_len, en);
          if (ef) begin
            cur_words  = 0;
            first_data = o_data;
            first_lat  = cyc - last_cyc;
          end
          cur_words++;
          in_frame = !el;
          if (el) begin
            frames_done++;
            last_data  = o_data;
            last_words = cur_words;
          end
        end
      end else begin
        if (in_frame) begin
          chk("bubble_enb", o_enb, 1'b1);
          in_frame = 1'b0;
        end
        chk("data_hold", o_data, held);
      end
      held = o_data;
    end
  end

  task automatic push_frame(input int n, input int base);
    int kept;
    kept = (n > MAXW) ? MAXW : n;
`ifdef TASK_FRAME_IN_OVF_DROP_EN
    if (n > MAXW) kept = 0;
`endif
    for (int i = 0; i < kept; i++) begin
      exp_data.push_back(8'(base + i));
      exp_first.push_back(i == 0);
      exp_last.push_back(i == kept - 1);
      exp_len.push_back(kept);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last);
    int t = 0;
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tlast = last;
    while (o_tready !== 1'b1) begin
      t++;
      if (t > 3000) timeout("tready_wait", t);
      @(negedge clk);
    end
    if (last) last_cyc = cyc;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base);
    push_frame(n, base);
    if (n > MAXW) exp_ovf++;
    for (int i = 0; i < n; i++) send_beat(8'(base + i), i == n - 1);
  endtask

  task automatic wait_frames(input int k);
    int t = 0;
    while (frames_done < k) begin
      @(negedge clk);
      t++;
      if (t > 5000) timeout("frame_replay_wait", t);
    end
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (!(in_frame && cur_words >= n)) begin
      @(negedge clk);
      t++;
      if (t > 5000) timeout("word_replay_wait", t);
    end
  endtask

  task automatic pulse_release();
    @(negedge clk);
    output_last = 1'b1;
    @(negedge clk);
    output_last = 1'b0;
  endtask

  initial begin
    int fd;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", o_tready, 1'b0);
    chk("rst_enb", o_enb, 1'b0);
    chk("rst_first", o_first, 1'b0);
    chk("rst_last", o_last, 1'b0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_frame_len", o_frame_len, 8'd0);
    chk("rst_overflow", o_overflow, 1'b0);
    rst_n = 1'b1;
    chk("tready_before_edge", o_tready, 1'b0);
    @(negedge clk);
    chk("tready_after_edge", o_tready, 1'b1);

    // full-size frame 0x00..0xF2
    send_frame(243, 0);
    wait_frames(1);
    chk("single_latency", first_lat, 3);
    chk("single_first_data", first_data, 8'h00);
    chk("single_last_data", last_data, 8'hF2);
    chk("single_words", last_words, 243);
    chk("single_len_reg", o_frame_len, 8'd243);
    pulse_release();

    // one-beat frame
    repeat (3) @(negedge clk);
    send_frame(1, 8'hA5);
    wait_frames(2);
    chk("onebeat_words", last_words, 1);
    chk("onebeat_data", last_data, 8'hA5);
    chk("onebeat_latency", first_lat, 3);
    pulse_release();

    // back-pressure with both banks occupied
    repeat (3) @(negedge clk);
    fd = frames_done;
    send_frame(10, 8'h10);
    send_frame(10, 8'h20);
    @(negedge clk);
    chk("bp_tready_full", o_tready, 1'b0);
    wait_frames(fd + 1);
    repeat (5) @(negedge clk);
    chk("bp_tready_still_full", o_tready, 1'b0);
    chk("bp_frame2_waits", frames_done, fd + 1);
    pulse_release();
    chk("bp_tready_after_release", o_tready, 1'b1);
    send_frame(10, 8'h30);
    wait_frames(fd + 2);
    pulse_release();
    wait_frames(fd + 3);
    chk("bp_frame3_last", last_data, 8'h39);
    pulse_release();

    // spurious releases in IDLE and in READ
    repeat (5) @(negedge clk);
    pulse_release();
    fd = frames_done;
    send_frame(20, 8'h40);
    wait_words(5);
    pulse_release();
    wait_frames(fd + 1);
    chk("spur_words", last_words, 20);
    send_frame(5, 8'h60);
    repeat (20) @(negedge clk);
    chk("spur_held_in_wait", frames_done, fd + 1);
    chk("spur_pending_words", exp_data.size(), 5);
    pulse_release();
    wait_frames(fd + 2);
    pulse_release();

    // oversize frame
    repeat (3) @(negedge clk);
    fd = frames_done;
    send_frame(250, 0);
    repeat (3) @(negedge clk);
    chk("ovf_pulse_count", ovf_cnt, 1);
`ifdef TASK_FRAME_IN_OVF_DROP_EN
    repeat (20) @(negedge clk);
    chk("ovf_drop_no_replay", frames_done, fd);
    chk("ovf_drop_tready", o_tready, 1'b1);
`else
    wait_frames(fd + 1);
    chk("ovf_trunc_words", last_words, 243);
    chk("ovf_trunc_last", last_data, 8'hF2);
    pulse_release();
`endif

    // reset in the middle of a replay
    repeat (3) @(negedge clk);
    fd = frames_done;
    send_frame(200, 8'h80);
    wait_words(100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", o_tready, 1'b0);
    chk("mid_rst_enb", o_enb, 1'b0);
    chk("mid_rst_first", o_first, 1'b0);
    chk("mid_rst_last", o_last, 1'b0);
    chk("mid_rst_data", o_data, 8'h00);
    chk("mid_rst_frame_len", o_frame_len, 8'd0);
    chk("mid_rst_overflow", o_overflow, 1'b0);
    exp_data.delete(); exp_first.delete(); exp_last.delete(); exp_len.delete();
    in_frame = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_tready_low", o_tready, 1'b0);
    @(negedge clk);
    chk("post_rst_tready_high", o_tready, 1'b1);
    send_frame(5, 8'hC0);
    wait_frames(fd + 1);
    chk("post_rst_words", last_words, 5);
    chk("post_rst_first", first_data, 8'hC0);
    pulse_release();

    repeat (5) @(negedge clk);
    chk("model_drained", exp_data.size(), 0);
    chk("ovf_total", ovf_cnt, exp_ovf);
    summary();
  end

  initial begin
    #2000000;
    timeout("global_watchdog", cyc);
  end
endmodule
